mdu_div_scheduler: RTL and testbench

Sequencing and arbitration controller for the single shared iterative divider of the RV32M execution stage. Accepts DIV/DIVU/REM/REMU operations from several issue ports (reservation-station slots), grants one at a time round-robin, and starts the divider datapath. Times the fixed divider latency and resolves divide-by-zero and signed overflow without using the divider. Returns the result with its ROB tag through a valid/ready port toward writeback/CDB.

---
 rtl/mdu_div_scheduler.sv | 157 +++++++++++++++
 tb/tb_mdu_div_scheduler.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mdu_div_scheduler.sv
// rtl/mdu_div_scheduler.sv - round-robin issue arbiter and sequencer for the shared RV32M iterative divider
module mdu_div_scheduler #(
    parameter int NUM_REQ     = 2,
    parameter int XLEN        = 32,
    parameter int TAG_W       = 5,
    parameter int DIV_LATENCY = 32
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic [NUM_REQ-1:0]       req_valid_i,
    output logic [NUM_REQ-1:0]       req_ready_o,
    input  logic [2*NUM_REQ-1:0]     req_op_i,
    input  logic [XLEN*NUM_REQ-1:0]  req_a_i,
    input  logic [XLEN*NUM_REQ-1:0]  req_b_i,
    input  logic [TAG_W*NUM_REQ-1:0] req_tag_i,
    output logic                     div_start_o,
    output logic [1:0]               div_op_o,
    output logic [XLEN-1:0]          div_a_o,
    output logic [XLEN-1:0]          div_b_o,
    output logic                     div_abort_o,
    input  logic [XLEN-1:0]          div_result_i,
    output logic                     res_valid_o,
    input  logic                     res_ready_i,
    output logic [XLEN-1:0]          res_data_o,
    output logic [TAG_W-1:0]         res_tag_o,
    input  logic                     flush_i,
    output logic                     busy_o
);
    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CNT_W = $clog2(DIV_LATENCY);
    localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_RESP} state_t;

    state_t               state, state_n;
    logic [PTR_W-1:0]     rr_ptr, grant_idx;
    logic [CNT_W-1:0]     cnt;
    logic                 start_q;
    logic [1:0]           op_q;
    logic [XLEN-1:0]      a_q, b_q, res_q;
    logic [TAG_W-1:0]     tag_q;
    logic [NUM_REQ-1:0]   grant;
    logic                 grant_any, accept, special;
    logic [1:0]           sel_op;
    logic [XLEN-1:0]      sel_a, sel_b, special_res;
    int                   gi;

    function automatic logic [PTR_W-1:0] wrap_idx(input logic [PTR_W-1:0] base, input int off);
        int s;
        s = int'(base) + off;
        if (s >= NUM_REQ) s = s - NUM_REQ;
        return PTR_W'(s);
    endfunction

    // Rotating priority: first valid port at or after rr_ptr wins.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        grant_any = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!grant_any && req_valid_i[wrap_idx(rr_ptr, i)]) begin
                grant_any                   = 1'b1;
                grant_idx                   = wrap_idx(rr_ptr, i);
                grant[wrap_idx(rr_ptr, i)]  = 1'b1;
            end
        end
    end

    assign gi     = int'(grant_idx);
    assign sel_op = req_op_i[gi*2 +: 2];
    assign sel_a  = req_a_i[gi*XLEN +: XLEN];
    assign sel_b  = req_b_i[gi*XLEN +: XLEN];
    assign accept = (state == S_IDLE) && !flush_i && grant_any;

    // Divide-by-zero and signed overflow resolve without the divider (op[0]=0 is signed, op[1]=1 is REM).
    always_comb begin
        special     = 1'b0;
        special_res = '0;
        if (sel_b == '0) begin
            special     = 1'b1;
            special_res = sel_op[1] ? sel_a : '1;
        end else if (!sel_op[0] && sel_a == INT_MIN && sel_b == '1) begin
            special     = 1'b1;
            special_res = sel_op[1] ? '0 : INT_MIN;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) state <= S_IDLE;
        else       state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            S_IDLE:  if (accept) state_n = special ? S_RESP : S_BUSY;
            S_BUSY:  if (cnt == '0) state_n = S_RESP;
            S_RESP:  if (res_ready_i) state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase
        if (flush_i) state_n = S_IDLE;
    end

    always_comb begin
        req_ready_o = '0;
        if (state == S_IDLE && !flush_i) req_ready_o = grant;
        div_start_o = (state == S_BUSY) && start_q;
        div_abort_o = flush_i && (state == S_BUSY);
        res_valid_o = (state == S_RESP);
        busy_o      = (state != S_IDLE);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rr_ptr  <= '0;
            cnt     <= '0;
            start_q <= 1'b0;
            op_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            tag_q   <= '0;
            res_q   <= '0;
        end else if (flush_i) begin
            cnt     <= '0;
            start_q <= 1'b0;
        end else begin
            case (state)
                S_IDLE: if (accept) begin
                    rr_ptr <= wrap_idx(grant_idx, 1);
                    op_q   <= sel_op;
                    a_q    <= sel_a;
                    b_q    <= sel_b;
                    tag_q  <= req_tag_i[gi*TAG_W +: TAG_W];
                    if (special) begin
                        res_q   <= special_res;
                        start_q <= 1'b0;
                    end else begin
                        cnt     <= CNT_W'(DIV_LATENCY - 1);
                        start_q <= 1'b1;
                    end
                end
                S_BUSY: begin
                    start_q <= 1'b0;
                    if (cnt == '0) res_q <= div_result_i;
                    else           cnt   <= cnt - CNT_W'(1);
                end
                default: ;
            endcase
        end
    end

    assign div_op_o   = op_q;
    assign div_a_o    = a_q;
    assign div_b_o    = b_q;
    assign res_data_o = res_q;
    assign res_tag_o  = tag_q;
endmodule

// File: tb/tb_mdu_div_scheduler.sv
// tb/tb_mdu_div_scheduler.sv - directed self-checking bench for mdu_div_scheduler
module tb_mdu_div_scheduler;
    localparam int L = 32;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  req_valid, req_ready;
    logic [3:0]  req_op;
    logic [63:0] req_a, req_b;
    logic [9:0]  req_tag;
    logic        div_start, div_abort, res_valid, res_ready, flush, busy;
    logic [1:0]  div_op;
    logic [31:0] div_a, div_b, div_result, res_data;
    logic [4:0]  res_tag;

    mdu_div_scheduler #(.NUM_REQ(2), .XLEN(32), .TAG_W(5), .DIV_LATENCY(L)) dut (
        .clk_i(clk), .rst_i(rst),
        .req_valid_i(req_valid), .req_ready_o(req_ready), .req_op_i(req_op),
        .req_a_i(req_a), .req_b_i(req_b), .req_tag_i(req_tag),
        .div_start_o(div_start), .div_op_o(div_op), .div_a_o(div_a), .div_b_o(div_b),
        .div_abort_o(div_abort), .div_result_i(div_result),
        .res_valid_o(res_valid), .res_ready_i(res_ready), .res_data_o(res_data), .res_tag_o(res_tag),
        .flush_i(flush), .busy_o(busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Divider stand-in: result only valid in cycle L-1 after the start cycle.
    int starts = 0;
    int dcnt   = 1000;
    function automatic logic [31:0] div_model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        case (op)
            2'b00:   return 32'($signed(a) / $signed(b));
            2'b01:   return a / b;
            2'b10:   return 32'($signed(a) % $signed(b));
            default: return a % b;
        endcase
    endfunction

    initial div_result = 32'hDEAD_BEEF;
    always @(negedge clk) begin
        if (div_start) begin
            dcnt = 0;
            starts++;
        end else if (dcnt < 1000) dcnt++;
        div_result = (dcnt == L-1 && div_b != 0) ? div_model(div_op, div_a, div_b) : 32'hDEAD_BEEF;
    end

    logic       rec_en = 1'b0;
    logic [1:0] grants[$];
    int         gcyc[$];
    always @(negedge clk) begin
        if (rec_en && (req_ready & req_valid) != 2'b00) begin
            grants.push_back(req_ready);
            gcyc.push_back(cyc);
        end
    end

    task automatic set_port(input int p, input logic [1:0] op, input logic [31:0] a,
                            input logic [31:0] b, input logic [4:0] tag);
        req_op[p*2 +: 2]   = op;
        req_a[p*32 +: 32]  = a;
        req_b[p*32 +: 32]  = b;
        req_tag[p*5 +: 5]  = tag;
    endtask

    task automatic issue(input int p, input logic [1:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [4:0] tag, output int hs);
        set_port(p, op, a, b, tag);
        req_valid[p] = 1'b1;
        hs = -1;
        for (int k = 0; k < 60; k++) begin
            #1;
            if (req_ready[p]) begin
                @(posedge clk);
                #1;
                hs = cyc;
                break;
            end
            @(posedge clk);
        end
        req_valid[p] = 1'b0;
        if (hs < 0) check("grant_timeout", 0, 1);
    endtask

    task automatic wait_resp(input string nm, input int hs, input int lat,
                             input logic [31:0] data, input logic [4:0] tag);
        bit seen = 0;
        for (int k = 0; k < 100; k++) begin
            if (res_valid) begin
                seen = 1;
                break;
            end
            @(posedge clk);
            #1;
        end
        if (!seen) check({nm, "_timeout"}, 0, 1);
        else begin
            check({nm, "_latency"}, cyc - hs, lat);
            check({nm, "_data"}, res_data, data);
            check({nm, "_tag"}, {27'd0, res_tag}, {27'd0, tag});
        end
    endtask

    task automatic consume();
        res_ready = 1'b1;
        @(posedge clk);
        #1;
        res_ready = 1'b0;
        check("consume_idle", {31'd0, busy}, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    int hs, s0, vcount;

    initial begin
        rst = 1'b1; flush = 1'b0; res_ready = 1'b0;
        req_valid = '0; req_op = '0; req_a = '0; req_b = '0; req_tag = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", {31'd0, busy}, 0);
        check("rst_res_valid", {31'd0, res_valid}, 0);
        check("rst_div_start", {31'd0, div_start}, 0);
        check("rst_res_data", res_data, 0);
        rst = 1'b0;

        // Normal DIVU and signed DIV/REM through the divider
        s0 = starts;
        issue(0, 2'b01, 32'd100, 32'd7, 5'd3, hs);
        wait_resp("divu", hs, L, 32'd14, 5'd3);
        check("divu_start_count", starts - s0, 1);
        consume();
        issue(1, 2'b00, 32'hFFFF_FF9C, 32'd7, 5'd12, hs);
        wait_resp("div_neg", hs, L, 32'hFFFF_FFF2, 5'd12);
        consume();
        issue(0, 2'b10, 32'hFFFF_FF9C, 32'd7, 5'd13, hs);
        wait_resp("rem_neg", hs, L, 32'hFFFF_FFFE, 5'd13);
        consume();

        // Special cases bypass the divider
        s0 = starts;
        issue(1, 2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 5'd7, hs);
        wait_resp("div_ovf", hs, 0, 32'h8000_0000, 5'd7);
        consume();
        issue(0, 2'b11, 32'd5, 32'd0, 5'd9, hs);
        wait_resp("remu_zero", hs, 0, 32'd5, 5'd9);
        consume();
        issue(1, 2'b00, 32'd42, 32'd0, 5'd10, hs);
        wait_resp("div_zero", hs, 0, 32'hFFFF_FFFF, 5'd10);
        consume();
        issue(0, 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 5'd14, hs);
        wait_resp("rem_ovf", hs, 0, 32'd0, 5'd14);
        consume();
        check("special_no_start", starts - s0, 0);

        // Flush while BUSY with cnt=10
        issue(0, 2'b01, 32'd1000, 32'd10, 5'd4, hs);
        repeat (21) @(posedge clk);
        #1;
        flush = 1'b1;
        req_valid = 2'b11;
        #1;
        check("flush_abort", {31'd0, div_abort}, 1);
        check("flush_ready_low", {30'd0, req_ready}, 0);
        req_valid = 2'b00;
        @(posedge clk);
        #1;
        flush = 1'b0;
        check("flush_idle", {31'd0, busy}, 0);
        check("flush_abort_clear", {31'd0, div_abort}, 0);
        vcount = 0;
        for (int k = 0; k < 20; k++) begin
            @(posedge clk);
            #1;
            if (res_valid) vcount++;
        end
        check("flush_no_result", vcount, 0);
        issue(1, 2'b01, 32'd50, 32'd5, 5'd6, hs);
        wait_resp("post_flush", hs, L, 32'd10, 5'd6);
        consume();

        // Backpressure in RESP
        issue(0, 2'b11, 32'd5, 32'd0, 5'd11, hs);
        wait_resp("bp", hs, 0, 32'd5, 5'd11);
        req_valid = 2'b11;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk);
            #1;
            check("bp_valid", {31'd0, res_valid}, 1);
            check("bp_data", res_data, 32'd5);
            check("bp_tag", {27'd0, res_tag}, 32'd11);
            check("bp_ready_low", {30'd0, req_ready}, 0);
        end
        req_valid = 2'b00;
        consume();
        check("bp_released", {31'd0, res_valid}, 0);

        // Round robin with both ports always valid
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        set_port(0, 2'b01, 32'd100, 32'd7, 5'd1);
        set_port(1, 2'b01, 32'd100, 32'd7, 5'd2);
        res_ready = 1'b1;
        rec_en = 1'b1;
        req_valid = 2'b11;
        for (int k = 0; k < 8*(L+2)+20 && grants.size() < 8; k++) @(posedge clk);
        #1;
        req_valid = 2'b00;
        rec_en = 1'b0;
        check("rr_grant_count", grants.size(), 8);
        for (int i = 0; i < 8 && i < grants.size(); i++)
            check($sformatf("rr_grant%0d", i), {30'd0, grants[i]}, (i % 2 == 0) ? 32'd1 : 32'd2);
        if (gcyc.size() >= 2) check("rr_spacing", gcyc[1] - gcyc[0], L + 2);
        repeat (L + 4) @(posedge clk);
        #1;
        res_ready = 1'b0;

        // Reset while BUSY
        issue(0, 2'b01, 32'd100, 32'd7, 5'd3, hs);
        repeat (5) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("rstb_busy", {31'd0, busy}, 0);
        check("rstb_start", {31'd0, div_start}, 0);
        check("rstb_valid", {31'd0, res_valid}, 0);
        check("rstb_div_a", div_a, 0);
        check("rstb_res_data", res_data, 0);
        check("rstb_tag", {27'd0, res_tag}, 0);
        rst = 1'b0;
        req_valid = 2'b11;
        #1;
        check("rstb_rr_ptr", {30'd0, req_ready}, 32'd1);
        req_valid = 2'b00;

        // Reset while in RESP
        @(posedge clk);
        #1;
        issue(0, 2'b11, 32'd5, 32'd0, 5'd8, hs);
        wait_resp("rstr_pre", hs, 0, 32'd5, 5'd8);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("rstr_valid", {31'd0, res_valid}, 0);
        check("rstr_busy", {31'd0, busy}, 0);
        check("rstr_data", res_data, 0);
        check("rstr_tag", {27'd0, res_tag}, 0);
        rst = 1'b0;
        req_valid = 2'b11;
        #1;
        check("rstr_rr_ptr", {30'd0, req_ready}, 32'd1);
        req_valid = 2'b00;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
